// File: rtl/mdu_pkg.sv
// Shared encodings for the multiply/divide unit: op codes, FSM states, iteration count.
// MUL_RUN exists only when MDU_ITER_MUL_EN is defined.
package mdu_pkg;

    localparam int MDU_DIV_ITERS = 32;

    localparam logic [2:0] MDU_MULT  = 3'd0;
    localparam logic [2:0] MDU_MULTU = 3'd1;
    localparam logic [2:0] MDU_DIV   = 3'd2;
    localparam logic [2:0] MDU_DIVU  = 3'd3;
    localparam logic [2:0] MDU_MTHI  = 3'd4;
    localparam logic [2:0] MDU_MTLO  = 3'd5;

    typedef enum logic [1:0] {
        IDLE,
        DIV_RUN,
        DIV_FIX
`ifdef MDU_ITER_MUL_EN
        , MUL_RUN
`endif
    } mdu_state_e;

endpackage

// File: rtl/mul_div_unit_div_core.sv
// Unsigned radix-2 restoring divider: one quotient bit per cycle after start.
// last is high during the final iteration; quotient/remainder are valid the cycle after.
module div_core #(
    parameter int DATA_W    = 32,
    parameter int DIV_ITERS = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              cancel,
    input  logic [DATA_W-1:0] dividend,
    input  logic [DATA_W-1:0] divisor,
    output logic              last,
    output logic [DATA_W-1:0] quotient,
    output logic [DATA_W-1:0] remainder
);
    localparam int CNT_W = $clog2(DIV_ITERS);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIV_ITERS - 1);

    logic              run;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] rem, quo, dvs;
    logic [DATA_W:0]   rem_sh, diff;

    // Dividend bits shift out of quo into rem while quotient bits shift in behind them.
    assign rem_sh = {rem, quo[DATA_W-1]};
    assign diff   = rem_sh - {1'b0, dvs};
    assign last   = run && (cnt == LAST_CNT);

    always_ff @(posedge clk) begin
        if (rst) begin
            run <= 1'b0;
            cnt <= '0;
            rem <= '0;
            quo <= '0;
            dvs <= '0;
        end else if (cancel) begin
            run <= 1'b0;
        end else if (start) begin
            run <= 1'b1;
            cnt <= '0;
            rem <= '0;
            quo <= dividend;
            dvs <= divisor;
        end else if (run) begin
            if (!diff[DATA_W]) begin
                rem <= diff[DATA_W-1:0];
                quo <= {quo[DATA_W-2:0], 1'b1};
            end else begin
                rem <= rem_sh[DATA_W-1:0];
                quo <= {quo[DATA_W-2:0], 1'b0};
            end
            cnt <= cnt + 1'b1;
            if (last) run <= 1'b0;
        end
    end

    assign quotient  = quo;
    assign remainder = rem;

endmodule

// File: rtl/mul_div_unit.sv
// EX-stage multiply/divide unit owning HI/LO; stalls the pipe via busy during division.
// Define MDU_ITER_MUL_EN to replace the single-cycle multiplier with a 32-step shift-add one.
module mul_div_unit
    import mdu_pkg::*;
#(
    parameter int DIV_ITERS = MDU_DIV_ITERS,
    parameter int DATA_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              op_valid,
    input  logic [2:0]        op,
    input  logic [DATA_W-1:0] src_a,
    input  logic [DATA_W-1:0] src_b,
    input  logic              cancel,
    output logic              op_ready,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo
);
    mdu_state_e state_q, state_d;

    logic              accept, signed_op, is_div;
    logic [DATA_W-1:0] mag_a, mag_b;
    logic              sign_q, sign_r, div_zero;
    logic [DATA_W-1:0] a_raw;
    logic              core_last;
    logic [DATA_W-1:0] core_quo, core_rem, quo_fix, rem_fix;

    assign busy      = (state_q != IDLE);
    assign op_ready  = ~busy;
    assign accept    = op_valid && op_ready && !cancel;
    assign signed_op = (op == MDU_DIV) || (op == MDU_MULT);
    assign is_div    = (op == MDU_DIV) || (op == MDU_DIVU);
    assign mag_a     = (signed_op && src_a[DATA_W-1]) ? -src_a : src_a;
    assign mag_b     = (signed_op && src_b[DATA_W-1]) ? -src_b : src_b;

    div_core #(.DATA_W(DATA_W), .DIV_ITERS(DIV_ITERS)) u_div (
        .clk       (clk),
        .rst       (rst),
        .start     (accept && is_div),
        .cancel    (cancel),
        .dividend  (mag_a),
        .divisor   (mag_b),
        .last      (core_last),
        .quotient  (core_quo),
        .remainder (core_rem)
    );

    assign quo_fix = sign_q ? -core_quo : core_quo;
    assign rem_fix = sign_r ? -core_rem : core_rem;

`ifdef MDU_ITER_MUL_EN
    localparam int CNT_W = $clog2(DIV_ITERS);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIV_ITERS - 1);

    logic                is_mul, fix_mul;
    logic [DATA_W-1:0]   mcand, prod_hi, prod_lo;
    logic [CNT_W-1:0]    mul_cnt;
    logic [DATA_W:0]     mul_sum;
    logic [2*DATA_W-1:0] prod_fix;

    assign is_mul   = (op == MDU_MULT) || (op == MDU_MULTU);
    // Multiplier bits leave prod_lo from the bottom as product bits enter from prod_hi.
    assign mul_sum  = {1'b0, prod_hi} + {1'b0, (prod_lo[0] ? mcand : {DATA_W{1'b0}})};
    assign prod_fix = sign_q ? -{prod_hi, prod_lo} : {prod_hi, prod_lo};

    always_ff @(posedge clk) begin
        if (rst) begin
            mcand   <= '0;
            prod_hi <= '0;
            prod_lo <= '0;
            mul_cnt <= '0;
            fix_mul <= 1'b0;
        end else if (accept) begin
            fix_mul <= is_mul;
            if (is_mul) begin
                mcand   <= mag_a;
                prod_hi <= '0;
                prod_lo <= mag_b;
                mul_cnt <= '0;
            end
        end else if (state_q == MUL_RUN) begin
            prod_hi <= mul_sum[DATA_W:1];
            prod_lo <= {mul_sum[0], prod_lo[DATA_W-1:1]};
            mul_cnt <= mul_cnt + 1'b1;
        end
    end
`else
    logic [2*DATA_W-1:0] ext_a, ext_b, prod_now;

    assign ext_a    = {{DATA_W{signed_op & src_a[DATA_W-1]}}, src_a};
    assign ext_b    = {{DATA_W{signed_op & src_b[DATA_W-1]}}, src_b};
    assign prod_now = ext_a * ext_b;
`endif

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept && is_div) state_d = DIV_RUN;
`ifdef MDU_ITER_MUL_EN
                if (accept && is_mul) state_d = MUL_RUN;
`endif
            end
            DIV_RUN: begin
                if (cancel)         state_d = IDLE;
                else if (core_last) state_d = DIV_FIX;
            end
`ifdef MDU_ITER_MUL_EN
            MUL_RUN: begin
                if (cancel)                    state_d = IDLE;
                else if (mul_cnt == LAST_CNT)  state_d = DIV_FIX;
            end
`endif
            DIV_FIX: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hi       <= '0;
            lo       <= '0;
            done     <= 1'b0;
            sign_q   <= 1'b0;
            sign_r   <= 1'b0;
            div_zero <= 1'b0;
            a_raw    <= '0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                sign_q   <= signed_op & (src_a[DATA_W-1] ^ src_b[DATA_W-1]);
                sign_r   <= signed_op & src_a[DATA_W-1];
                div_zero <= (src_b == '0);
                a_raw    <= src_a;
                case (op)
                    MDU_MTHI: hi <= src_a;
                    MDU_MTLO: lo <= src_a;
`ifndef MDU_ITER_MUL_EN
                    MDU_MULT, MDU_MULTU: begin
                        {hi, lo} <= prod_now;
                        done     <= 1'b1;
                    end
`endif
                    default: ;
                endcase
            end
            if (state_q == DIV_FIX && !cancel) begin
                done <= 1'b1;
`ifdef MDU_ITER_MUL_EN
                if (fix_mul) begin
                    {hi, lo} <= prod_fix;
                end else
`endif
                if (div_zero) begin
                    hi <= a_raw;
                    lo <= '1;
                end else begin
                    hi <= rem_fix;
                    lo <= quo_fix;
                end
            end
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: products, quotients, divide-by-zero, stall, cancel, reset.
module tb_mul_div_unit;
    import mdu_pkg::*;

`ifdef MDU_ITER_MUL_EN
    localparam int MUL_BUSY = 33;
`else
    localparam int MUL_BUSY = 0;
`endif

    logic        clk = 1'b0;
    logic        rst, op_valid, cancel;
    logic [2:0]  op;
    logic [31:0] src_a, src_b;
    logic        op_ready, busy, done;
    logic [31:0] hi, lo;

    int checks   = 0;
    int failures = 0;

    mul_div_unit dut (
        .clk      (clk),
        .rst      (rst),
        .op_valid (op_valid),
        .op       (op),
        .src_a    (src_a),
        .src_b    (src_b),
        .cancel   (cancel),
        .op_ready (op_ready),
        .busy     (busy),
        .done     (done),
        .hi       (hi),
        .lo       (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input string tag, input logic [2:0] c, input logic [31:0] a,
                          input logic [31:0] b, input int exp_busy,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int n  = 0;
        int dn = 0;
        op_valid = 1'b1; op = c; src_a = a; src_b = b;
        step();
        op_valid = 1'b0;
        while (busy && n < 100) begin
            n++;
            if (done) dn++;
            step();
        end
        check({tag, " busy_cycles"}, 64'(n), 64'(exp_busy));
        check({tag, " early_done"}, 64'(dn), 64'd0);
        check({tag, " done"}, 64'(done), 64'd1);
        check({tag, " hi"}, 64'(hi), 64'(exp_hi));
        check({tag, " lo"}, 64'(lo), 64'(exp_lo));
        step();
        check({tag, " done_once"}, 64'(done), 64'd0);
    endtask

    task automatic drive1(input logic [2:0] c, input logic [31:0] a, input logic can);
        op_valid = 1'b1; op = c; src_a = a; src_b = 32'd0; cancel = can;
        step();
        op_valid = 1'b0; cancel = 1'b0;
    endtask

    initial begin
        int n;
        logic [31:0] hprev;
        rst = 1'b1; op_valid = 1'b0; cancel = 1'b0; op = 3'd0; src_a = '0; src_b = '0;
        step(); step();
        rst = 1'b0;
        check("reset hi", 64'(hi), 64'd0);
        check("reset lo", 64'(lo), 64'd0);
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset op_ready", 64'(op_ready), 64'd1);

        run_op("mult_neg",  MDU_MULT,  32'hFFFFFFFE, 32'd3, MUL_BUSY, 32'hFFFFFFFF, 32'hFFFFFFFA);
        run_op("multu",     MDU_MULTU, 32'hFFFFFFFE, 32'd3, MUL_BUSY, 32'h00000002, 32'hFFFFFFFA);
        run_op("mult_max",  MDU_MULT,  32'h7FFFFFFF, 32'h7FFFFFFF, MUL_BUSY, 32'h3FFFFFFF, 32'h00000001);
        run_op("div_neg",   MDU_DIV,   32'hFFFFFFF9, 32'd2, 33, 32'hFFFFFFFF, 32'hFFFFFFFD);
        run_op("div_negb",  MDU_DIV,   32'd7, 32'hFFFFFFFE, 33, 32'd1, 32'hFFFFFFFD);
        run_op("divu",      MDU_DIVU,  32'd100, 32'd7, 33, 32'd2, 32'd14);
        run_op("divu_zero", MDU_DIVU,  32'd5, 32'd0, 33, 32'd5, 32'hFFFFFFFF);
        run_op("div_zero",  MDU_DIV,   32'hFFFFFFF9, 32'd0, 33, 32'hFFFFFFF9, 32'hFFFFFFFF);
        run_op("div_ovf",   MDU_DIV,   32'h80000000, 32'hFFFFFFFF, 33, 32'd0, 32'h80000000);

        // MTHI held during a divide waits for busy to drop.
        hprev = hi;
        op_valid = 1'b1; op = MDU_DIVU; src_a = 32'd100; src_b = 32'd7;
        step();
        op = MDU_MTHI; src_a = 32'h1234;
        n = 0;
        while (busy && n < 100) begin
            n++;
            if (n == 5) check("stall hi_held", 64'(hi), 64'(hprev));
            step();
        end
        check("stall busy_cycles", 64'(n), 64'd33);
        check("stall rem_first", 64'(hi), 64'd2);
        check("stall op_ready", 64'(op_ready), 64'd1);
        step();
        op_valid = 1'b0;
        check("stall mthi", 64'(hi), 64'h1234);
        check("stall lo", 64'(lo), 64'd14);

        // Cancel mid-divide.
        drive1(MDU_MTLO, 32'hAAAA, 1'b0);
        check("mtlo lo", 64'(lo), 64'hAAAA);
        check("mtlo no_done", 64'(done), 64'd0);
        hprev = hi;
        op_valid = 1'b1; op = MDU_DIVU; src_a = 32'd100; src_b = 32'd7;
        step();
        op_valid = 1'b0;
        repeat (9) step();
        check("cancel busy_before", 64'(busy), 64'd1);
        cancel = 1'b1;
        step();
        cancel = 1'b0;
        check("cancel busy", 64'(busy), 64'd0);
        n = 0;
        repeat (40) begin
            if (done || busy) n++;
            step();
        end
        check("cancel no_done", 64'(n), 64'd0);
        check("cancel lo", 64'(lo), 64'hAAAA);
        check("cancel hi", 64'(hi), 64'(hprev));

        // Reset mid-divide.
        op_valid = 1'b1; op = MDU_DIV; src_a = 32'hFFFFFFF9; src_b = 32'd2;
        step();
        op_valid = 1'b0;
        repeat (9) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst hi", 64'(hi), 64'd0);
        check("rst lo", 64'(lo), 64'd0);
        check("rst busy", 64'(busy), 64'd0);
        n = 0;
        repeat (40) begin
            if (done || busy) n++;
            step();
        end
        check("rst no_done", 64'(n), 64'd0);

        // Cancel alongside a command drops it.
        drive1(MDU_MTHI, 32'h5555, 1'b1);
        check("drop mthi", 64'(hi), 64'd0);
        op_valid = 1'b1; op = MDU_MULT; src_a = 32'd3; src_b = 32'd3; cancel = 1'b1;
        step();
        op_valid = 1'b0; cancel = 1'b0;
        check("drop mult lo", 64'(lo), 64'd0);
        check("drop mult done", 64'(done), 64'd0);
        check("drop mult busy", 64'(busy), 64'd0);

        // Reserved op code has no effect.
        drive1(3'd6, 32'h9999, 1'b0);
        check("rsvd hi", 64'(hi), 64'd0);
        check("rsvd lo", 64'(lo), 64'd0);
        check("rsvd done", 64'(done), 64'd0);
        check("rsvd busy", 64'(busy), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Execution-side responder for the multiply/divide/HI-LO class decoded by the control unit: MULT, MULTU, DIV, DIVU, MTHI, MTLO.
- Owns the architectural HI/LO registers and sources MFHI/MFLO read data.
- Sits in EX beside the ALU. Accepts one command per handshake and raises busy during multi-cycle division so the pipeline stalls.

Parameters:
- DIV_ITERS, 32, radix-2 restoring-division iterations; must equal the operand width.
- DATA_W, 32, operand and HI/LO width.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- op_valid  input  1  command present this cycle
- op  input  3  command code (shared package encoding)
- src_a  input  DATA_W  rs value: dividend, multiplicand, or MTHI/MTLO data
- src_b  input  DATA_W  rt value: divisor or multiplier
- cancel  input  1  exception/flush: abort in-flight op
- op_ready  output  1  = ~busy; command accepted when op_valid & op_ready
- busy  output  1  multi-cycle op in progress
- done  output  1  one-cycle pulse when a MULT*/DIV* result lands in HI/LO
- hi  output  DATA_W  architectural HI
- lo  output  DATA_W  architectural LO

Behaviour:
- Reset values: hi=0, lo=0, busy=0, done=0, op_ready=1, FSM=IDLE.
- Reset mid-operation aborts and clears everything to reset values.
- FSM states and transitions:
  - IDLE: wait for an accepted command.
  - DIV_RUN: iteration counter runs 0..DIV_ITERS-1.
  - DIV_FIX: sign correction and HI/LO write.
  - IDLE -> DIV_RUN on accepted DIV/DIVU.
  - DIV_RUN -> DIV_FIX after iteration DIV_ITERS-1.
  - DIV_FIX -> IDLE.
- Operand handling for signed ops: magnitudes are latched at accept; sign_q = a[31]^b[31], sign_r = a[31].
- MULT/MULTU, accepted in cycle N:
  - {hi,lo} = 64-bit product (signed or unsigned) written at the end of cycle N.
  - done=1 in cycle N+1; busy stays 0.
- DIV/DIVU, accepted in cycle N:
  - busy=1 in cycles N+1..N+33 (32 iterations plus DIV_FIX).
  - lo=quotient, hi=remainder written at the end of N+33.
  - done=1 and busy=0 in cycle N+34. A new command may be accepted in N+34.
- Signed results: quotient negated if sign_q; remainder negated if sign_r. The remainder takes the dividend's sign.
- Divide by zero (both variants): lo=32'hFFFFFFFF, hi=src_a as latched. Normal latency, done pulses.
- Overflow: 0x80000000 / 0xFFFFFFFF (signed) gives lo=0x80000000, hi=0, no flag.
- MTHI/MTLO: write src_a to hi or lo at the end of the accept cycle. No done pulse.
- While busy: op_ready=0; op_valid is ignored and upstream holds the command.
- Reads: hi/lo always reflect committed values, never partial division state. MFHI/MFLO must stall on busy externally.
- cancel:
  - In DIV_RUN/DIV_FIX: return to IDLE next cycle; hi/lo unchanged; no done.
  - With op_valid in the same cycle: cancel wins and the command is dropped, including MTHI/MTLO and MULT.
- Reserved op codes when accepted: no effect.

Optional Feature:
- Macro MDU_ITER_MUL_EN.
- Defined:
  - MULT/MULTU use an iterative shift-add multiplier in added state MUL_RUN.
  - busy=1 for 33 cycles (32 iterations plus sign fix), same timing as divide.
  - done in cycle N+34.
  - cancel and reset rules are the same as for divide.
- Undefined: single-cycle multiply as above, and the MUL_RUN state is absent.

Decomposition:
- Shared package mdu_pkg holds:
  - op codes: MDU_MULT=3'd0, MDU_MULTU=3'd1, MDU_DIV=3'd2, MDU_DIVU=3'd3, MDU_MTHI=3'd4, MDU_MTLO=3'd5; 6-7 reserved.
  - FSM state typedef.
  - DIV_ITERS default.
- One natural sub-module, div_core: unsigned restoring divider datapath (remainder/quotient shift registers, counter), with start/cancel in and done/quotient/remainder out. mul_div_unit owns sign handling, HI/LO and the handshake.

Test Plan:
- MULT src_a=0xFFFFFFFE (-2), src_b=3 -> next cycle hi=0xFFFFFFFF, lo=0xFFFFFFFA, done=1, busy never 1. MULTU with the same operands -> hi=0x00000002, lo=0xFFFFFFFA.
- DIV src_a=0xFFFFFFF9 (-7), src_b=2 -> busy for 33 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF, done pulse exactly once. DIVU 100/7 -> lo=14, hi=2.
- DIVU 5/0 -> lo=0xFFFFFFFF, hi=5 after 33 busy cycles. Signed 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- During DIV, issue MTHI 0x1234 held valid -> not accepted until the cycle busy drops, then hi=0x1234 next cycle, overwriting the DIV remainder.
- MTLO 0xAAAA; DIV started; cancel at busy cycle 10 -> busy=0 next cycle, lo stays 0xAAAA, no done. Repeat with rst instead -> hi=lo=0.
- With MDU_ITER_MUL_EN defined: MULT 0x7FFFFFFF x 0x7FFFFFFF -> 33 busy cycles, then hi=0x3FFFFFFF, lo=0x00000001.
